// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status flag positions, exception cause codes
// and the exception-stage state enum.
package alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'd0;
    localparam logic [3:0] ALU_OR     = 4'd1;
    localparam logic [3:0] ALU_ADD    = 4'd2;
    localparam logic [3:0] ALU_DIV    = 4'd4;
    localparam logic [3:0] ALU_MUL    = 4'd5;
    localparam logic [3:0] ALU_SUB    = 4'd6;
    localparam logic [3:0] ALU_SLT    = 4'd7;
    localparam logic [3:0] ALU_SLL    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_XOR    = 4'd10;
    localparam logic [3:0] ALU_NOR    = 4'd11;
    localparam logic [3:0] ALU_ADDR_W = 4'd12;
    localparam logic [3:0] ALU_ADDR_H = 4'd13;

    localparam int STAT_ZERO     = 7;
    localparam int STAT_MUL_OVF  = 6;
    localparam int STAT_ADD_OVF  = 5;
    localparam int STAT_NEG      = 4;
    localparam int STAT_ALIGNED  = 3;
    localparam int STAT_DIV_ZERO = 2;

    localparam logic [3:0] CAUSE_NONE       = 4'h0;
    localparam logic [3:0] CAUSE_ADDR_LOAD  = 4'h4;
    localparam logic [3:0] CAUSE_ADDR_STORE = 4'h5;
    localparam logic [3:0] CAUSE_OVF        = 4'hC;
    localparam logic [3:0] CAUSE_DIV_ZERO   = 4'hF;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } exc_state_e;

    // Only word and halfword address opcodes are subject to alignment checks.
    function automatic logic is_addr_op(input logic [3:0] ctrl);
        return (ctrl == ALU_ADDR_W) || (ctrl == ALU_ADDR_H);
    endfunction

endpackage

// File: rtl/alu_exc_decode.sv
// Combinational exception detector for one ALU instruction; the first matching
// condition in priority order wins.
module alu_exc_decode
    import alu_pkg::*;
(
    input  logic [3:0] alu_control,
    input  logic [7:0] alu_status,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic       check_ovf,
    output logic       hit,
    output logic [3:0] cause
);

    logic div_zero;
    logic ovf;
    logic addr_op;
    logic misaligned;
    logic unused_status;

    assign unused_status = ^{alu_status[STAT_ZERO], alu_status[STAT_NEG], alu_status[1:0]};

    assign div_zero   = (alu_control == ALU_DIV) & alu_status[STAT_DIV_ZERO];
    assign ovf        = check_ovf & (alu_status[STAT_ADD_OVF] | alu_status[STAT_MUL_OVF]);
    assign addr_op    = is_addr_op(alu_control);
    assign misaligned = addr_op & ~alu_status[STAT_ALIGNED];

    always_comb begin
        hit   = 1'b1;
        cause = CAUSE_NONE;
        if (div_zero) begin
            cause = CAUSE_DIV_ZERO;
        end else if (ovf) begin
            cause = CAUSE_OVF;
        end else if (misaligned & mem_read) begin
            cause = CAUSE_ADDR_LOAD;
        end else if (misaligned & mem_write) begin
            cause = CAUSE_ADDR_STORE;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/alu_exc_stage.sv
// One-entry EX/MEM pipeline register that diverts faulting instructions into a
// pending exception (cause + EPC) instead of passing them downstream.
//
// state | meaning
// RUN   | normal flow, instructions accepted into the output register
// EXC   | exception pending, incoming instructions discarded until exc_ack
module alu_exc_stage
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_control,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [7:0]         alu_status,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [DATA_W-1:0]  in_store_data,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_reg_write,
    input  logic               in_check_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_result,
    output logic [DATA_W-1:0]  out_store_data,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_reg_write,
    input  logic               flush,
    output logic               exc_valid,
    output logic [3:0]         exc_cause,
    output logic [DATA_W-1:0]  exc_epc,
    input  logic               exc_ack
);

    exc_state_e state, state_nxt;
    logic       accept;
    logic       exc_hit;
    logic [3:0] exc_code;
    logic       load_out;
    logic       latch_exc;

    alu_exc_decode u_decode (
        .alu_control (alu_control),
        .alu_status  (alu_status),
        .mem_read    (in_mem_read),
        .mem_write   (in_mem_write),
        .check_ovf   (in_check_ovf),
        .hit         (exc_hit),
        .cause       (exc_code)
    );

    // While an exception is pending the stage swallows everything upstream.
    assign in_ready  = (state == EXC) ? 1'b1 : (~out_valid | out_ready);
    assign accept    = in_valid & in_ready;
    assign exc_valid = (state == EXC);

    always_comb begin
        state_nxt = state;
        load_out  = 1'b0;
        latch_exc = 1'b0;
        if (flush) begin
            state_nxt = state;
        end else if (state == EXC) begin
            if (exc_ack) begin
                state_nxt = RUN;
            end
        end else if (accept) begin
            if (exc_hit) begin
                state_nxt = EXC;
                latch_exc = 1'b1;
            end else begin
                load_out = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_store_data <= '0;
            out_rd         <= '0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_reg_write  <= 1'b0;
            exc_cause      <= CAUSE_NONE;
            exc_epc        <= '0;
        end else begin
            state <= state_nxt;

            if (flush) begin
                out_valid <= 1'b0;
            end else if (load_out) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (load_out) begin
                out_result     <= alu_result;
                out_store_data <= in_store_data;
                out_rd         <= in_rd;
                out_mem_read   <= in_mem_read;
                out_mem_write  <= in_mem_write;
                out_reg_write  <= in_reg_write;
            end

            if (latch_exc) begin
                exc_cause <= exc_code;
                exc_epc   <= in_pc;
            end
        end
    end

endmodule

// File: tb/tb_alu_exc_stage.sv
// Randomized scoreboard bench for alu_exc_stage: the driver predicts transfers
// and exceptions from the instruction rules, a monitor consumes the predictions.
module tb_alu_exc_stage;

    typedef struct {
        logic        valid;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic [7:0]  status;
        logic [31:0] pc;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        mr, mw, rw, ovf;
        logic        ordy, flush, ack, rst;
    } stim_t;

    typedef struct {
        logic [31:0] result;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        mr, mw, rw;
    } out_t;

    typedef struct {
        logic [3:0]  cause;
        logic [31:0] epc;
    } exc_t;

    logic        clk, rst, in_valid, in_ready;
    logic [3:0]  alu_control;
    logic [31:0] alu_result, in_pc, in_store_data;
    logic [7:0]  alu_status;
    logic [4:0]  in_rd;
    logic        in_mem_read, in_mem_write, in_reg_write, in_check_ovf;
    logic        out_valid, out_ready;
    logic [31:0] out_result, out_store_data;
    logic [4:0]  out_rd;
    logic        out_mem_read, out_mem_write, out_reg_write;
    logic        flush, exc_valid, exc_ack;
    logic [3:0]  exc_cause;
    logic [31:0] exc_epc;

    alu_exc_stage #(.DATA_W(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .alu_result(alu_result), .alu_status(alu_status),
        .in_pc(in_pc), .in_store_data(in_store_data), .in_rd(in_rd),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_reg_write(in_reg_write), .in_check_ovf(in_check_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_store_data(out_store_data), .out_rd(out_rd),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .flush(flush), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_epc(exc_epc), .exc_ack(exc_ack)
    );

    int total = 0;
    int bad   = 0;

    out_t q[$];
    exc_t eq[$];

    logic        cur_held = 0, nxt_held = 0;
    logic        cur_exc = 0, nxt_exc = 0;
    logic [3:0]  cur_cause = 0, nxt_cause = 0;
    logic [31:0] cur_epc = 0, nxt_epc = 0;
    logic        drop_all = 0, drop_held = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fault rules straight from the instruction semantics, highest priority first.
    function automatic logic [3:0] ref_cause(input stim_t s);
        logic addr_op;
        addr_op = (s.ctrl == 4'd12) || (s.ctrl == 4'd13);
        if (s.ctrl == 4'd4 && s.status[2])              return 4'hF;
        if (s.ovf && (s.status[5] || s.status[6]))      return 4'hC;
        if (addr_op && s.mr && !s.status[3])            return 4'h4;
        if (addr_op && s.mw && !s.status[3])            return 4'h5;
        return 4'h0;
    endfunction

    function automatic stim_t idle(input logic ordy);
        stim_t s;
        s = '{valid: 0, ctrl: 0, result: 0, status: 0, pc: 0, sdata: 0, rd: 0,
              mr: 0, mw: 0, rw: 0, ovf: 0, ordy: ordy, flush: 0, ack: 0, rst: 0};
        return s;
    endfunction

    function automatic stim_t mk(input logic [3:0] ctrl, input logic [31:0] res,
                                 input logic [7:0] st, input logic [31:0] pc,
                                 input logic mr, input logic mw, input logic ovf,
                                 input logic ordy);
        stim_t s;
        s = idle(ordy);
        s.valid = 1; s.ctrl = ctrl; s.result = res; s.status = st; s.pc = pc;
        s.sdata = $urandom; s.rd = 5'($urandom); s.rw = !mw;
        s.mr = mr; s.mw = mw; s.ovf = ovf;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        logic [3:0] ops [8];
        ops = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd6, 4'd10, 4'd12, 4'd13};
        s = mk(ops[$urandom_range(0, 7)], $urandom, 8'($urandom), $urandom & 32'hFFFF_FFFC,
               0, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        s.valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
            0: s.mr = 1;
            1: s.mw = 1;
            default: ;
        endcase
        s.rw = !s.mw;
        s.status[3] = ($urandom_range(0, 3) != 0);
        s.status[2] = ($urandom_range(0, 7) == 0);
        s.status[5] = ($urandom_range(0, 7) == 0);
        s.status[6] = ($urandom_range(0, 7) == 0);
        s.ack   = ($urandom_range(0, 3) == 0);
        s.flush = ($urandom_range(0, 24) == 0);
        s.rst   = ($urandom_range(0, 199) == 0);
        if (s.flush) begin
            s.ordy = 0;
            s.ack  = 0;
        end
        return s;
    endfunction

    // One clock of stimulus: check state left by the previous edge, apply inputs,
    // then predict what the coming edge does.
    task automatic drive(input stim_t s);
        logic  exp_rdy;
        logic  acc;
        logic [3:0] c;
        out_t  o;
        exc_t  e;
        @(posedge clk);
        #1;
        if (drop_all) begin
            q.delete();
            eq.delete();
        end else if (drop_held && q.size() > 0) begin
            void'(q.pop_back());
        end
        drop_all = 0; drop_held = 0;
        cur_held = nxt_held; cur_exc = nxt_exc;
        cur_cause = nxt_cause; cur_epc = nxt_epc;
        chk("out_valid", 32'(out_valid), 32'(cur_held));
        chk("exc_valid", 32'(exc_valid), 32'(cur_exc));
        chk("exc_cause", 32'(exc_cause), 32'(cur_cause));
        chk("exc_epc", exc_epc, cur_epc);

        rst = s.rst; flush = s.flush; exc_ack = s.ack; out_ready = s.ordy;
        in_valid = s.valid; alu_control = s.ctrl; alu_result = s.result;
        alu_status = s.status; in_pc = s.pc; in_store_data = s.sdata; in_rd = s.rd;
        in_mem_read = s.mr; in_mem_write = s.mw; in_reg_write = s.rw; in_check_ovf = s.ovf;
        #1;
        exp_rdy = cur_exc ? 1'b1 : (!cur_held || s.ordy);
        if (!s.rst) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = s.valid && exp_rdy;

        if (s.rst) begin
            nxt_held = 0; nxt_exc = 0; nxt_cause = 0; nxt_epc = 0;
            drop_all = 1;
        end else if (s.flush) begin
            nxt_held  = 0;
            drop_held = cur_held;
        end else begin
            nxt_held = cur_held && !s.ordy;
            if (cur_exc) begin
                if (s.ack) nxt_exc = 0;
            end else if (acc) begin
                c = ref_cause(s);
                if (c != 4'h0) begin
                    nxt_exc = 1; nxt_cause = c; nxt_epc = s.pc;
                    e.cause = c; e.epc = s.pc;
                    eq.push_back(e);
                end else begin
                    o.result = s.result; o.sdata = s.sdata; o.rd = s.rd;
                    o.mr = s.mr; o.mw = s.mw; o.rw = s.rw;
                    q.push_back(o);
                    nxt_held = 1;
                end
            end
        end
    endtask

    // Monitor: whatever the DUT presents must be the oldest predicted entry.
    initial begin
        logic prev_exc;
        exc_t e;
        prev_exc = 0;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && rst !== 1'b1) begin
                if (q.size() == 0) begin
                    chk("out_unexpected", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_result", out_result, q[0].result);
                    chk("out_store_data", out_store_data, q[0].sdata);
                    chk("out_rd", 32'(out_rd), 32'(q[0].rd));
                    chk("out_ctl", {29'd0, out_mem_read, out_mem_write, out_reg_write},
                        {29'd0, q[0].mr, q[0].mw, q[0].rw});
                    if (out_ready === 1'b1) void'(q.pop_front());
                end
            end
            if (exc_valid === 1'b1 && !prev_exc) begin
                if (eq.size() == 0) begin
                    chk("exc_unexpected", 32'(exc_valid), 32'd0);
                end else begin
                    e = eq.pop_front();
                    chk("exc_cause_sb", 32'(exc_cause), 32'(e.cause));
                    chk("exc_epc_sb", exc_epc, e.epc);
                end
            end
            prev_exc = (exc_valid === 1'b1);
        end
    end

    initial begin
        stim_t s;
        rst = 1; flush = 0; exc_ack = 0; out_ready = 0; in_valid = 0;
        alu_control = 0; alu_result = 0; alu_status = 0; in_pc = 0; in_store_data = 0;
        in_rd = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0; in_check_ovf = 0;

        s = idle(1); s.rst = 1;
        drive(s);
        drive(s);
        drive(idle(1));
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_exc_cause", 32'(exc_cause), 32'h0);

        // add passes straight through
        drive(mk(4'd2, 32'h10, 8'h00, 32'h100, 0, 0, 0, 1));
        drive(idle(1));
        chk("add_result", out_result, 32'h10);
        chk("add_no_exc", 32'(exc_valid), 32'h0);

        // misaligned word load
        drive(mk(4'd12, 32'h1002, 8'h00, 32'h400, 1, 0, 0, 1));
        drive(idle(1));
        chk("ld_cause", 32'(exc_cause), 32'h4);
        chk("ld_epc", exc_epc, 32'h400);
        chk("ld_out_valid", 32'(out_valid), 32'h0);
        s = idle(1); s.ack = 1;
        drive(s);

        // divide-by-zero outranks overflow
        drive(mk(4'd4, 32'h0, 8'h24, 32'h500, 0, 0, 1, 1));
        drive(idle(1));
        chk("prio_cause", 32'(exc_cause), 32'hF);
        drive(s);
        drive(idle(1));
        chk("ack_cause_held", 32'(exc_cause), 32'hF);

        // misaligned halfword store, then unaligned opcode stays silent
        drive(mk(4'd13, 32'h3, 8'h00, 32'h520, 0, 1, 0, 1));
        drive(s);
        drive(mk(4'd2, 32'h3, 8'h00, 32'h530, 1, 0, 0, 1));

        // stall for three cycles, then back-to-back transfer
        drive(mk(4'd6, 32'hAAAA, 8'h08, 32'h600, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            drive(mk(4'd2, 32'hB000 + i, 8'h08, 32'h604, 0, 0, 0, 0));
        chk("stall_ready", 32'(in_ready), 32'h0);
        drive(mk(4'd2, 32'hCCCC, 8'h08, 32'h608, 0, 0, 0, 1));
        drive(mk(4'd0, 32'hDDDD, 8'h08, 32'h60C, 0, 0, 0, 1));
        drive(idle(1));

        // pending exception discards three instructions; ack re-opens the stage
        drive(mk(4'd5, 32'h0, 8'h40, 32'h700, 0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            drive(mk(4'd2, 32'hE000 + i, 8'h08, 32'h704, 0, 0, 0, 1));
        drive(s);
        drive(mk(4'd2, 32'hF00D, 8'h08, 32'h710, 0, 0, 0, 1));
        drive(idle(1));
        chk("after_ack_result", out_result, 32'hF00D);

        // reset beats flush while an exception is pending
        drive(mk(4'd12, 32'h1001, 8'h00, 32'h800, 1, 0, 0, 1));
        drive(mk(4'd2, 32'h1234, 8'h08, 32'h804, 0, 0, 0, 0));
        s = idle(0); s.rst = 1; s.flush = 1;
        drive(s);
        drive(idle(1));
        chk("rf_exc_valid", 32'(exc_valid), 32'h0);
        chk("rf_epc", exc_epc, 32'h0);
        chk("rf_out_valid", 32'(out_valid), 32'h0);

        for (int i = 0; i < 3000; i++)
            drive(rnd());

        s = idle(1); s.ack = 1;
        for (int i = 0; i < 4; i++)
            drive(s);
        chk("sb_empty", 32'(q.size()), 32'h0);
        chk("exc_sb_empty", 32'(eq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exc_stage.md
ALU_EXC_STAGE -- requirements
Module: alu_exc_stage

Interface
REQ-001 Parameter DATA_W, default 32: datapath width of result, store data and PC.
REQ-002 Parameter RADDR_W, default 5: destination register address width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  upstream ALU stage holds a valid instruction.
REQ-006 in_ready  out  1  stage accepts the instruction this cycle.
REQ-007 alu_control  in  4  ALU opcode of the instruction.
REQ-008 alu_result  in  DATA_W  ALU result (address for loads/stores).
REQ-009 alu_status  in  8  ALU flags: [7] zero, [6] mul overflow, [5] add/sub overflow, [4] negative, [3] aligned, [2] divide-by-zero, [1:0] reserved.
REQ-010 in_pc  in  DATA_W  PC of the instruction.
REQ-011 in_store_data  in  DATA_W  rt value for stores.
REQ-012 in_rd  in  RADDR_W  destination register.
REQ-013 in_mem_read, in_mem_write, in_reg_write, in_check_ovf  in  1 each  control bits; check_ovf marks trapping signed ops.
REQ-014 out_valid  out  1  registered instruction presented to MEM stage.
REQ-015 out_ready  in  1  MEM stage consumes the presented instruction.
REQ-016 out_result, out_store_data  out  DATA_W each; out_rd  out  RADDR_W; out_mem_read, out_mem_write, out_reg_write  out  1 each.
REQ-017 flush  in  1  discard held and incoming instruction.
REQ-018 exc_valid  out  1  an exception is pending.
REQ-019 exc_cause  out  4  cause code of the pending exception.
REQ-020 exc_epc  out  DATA_W  PC of the faulting instruction.
REQ-021 exc_ack  in  1  handler has taken the exception.

Function
REQ-022 Stage SHALL be a one-entry pipeline register: accept when in_valid & in_ready; out_valid SHALL rise the next cycle (latency 1).
REQ-023 In state RUN, in_ready SHALL equal ~out_valid | out_ready (combinational); simultaneous drain and accept SHALL replace the entry with no bubble.
REQ-024 Detection, priority order: divide-by-zero (alu_control==4 & status[2]) -> cause 4'hF; overflow (in_check_ovf & (status[5] | status[6])) -> 4'hC; misaligned load (in_mem_read & ~status[3]) -> 4'h4; misaligned store (in_mem_write & ~status[3]) -> 4'h5.
REQ-025 Alignment check SHALL apply only when alu_control is 12 (word) or 13 (halfword); other opcodes SHALL never raise address errors.
REQ-026 An accepted faulting instruction SHALL NOT enter the output register; the stage SHALL latch cause and in_pc and move RUN -> EXC, exc_valid rising next cycle.
REQ-027 In EXC, in_ready SHALL be 1 and every incoming instruction SHALL be discarded; an older entry already held SHALL still drain normally.
REQ-028 exc_ack in EXC SHALL return the stage to RUN next cycle and clear exc_valid; exc_cause/exc_epc SHALL hold their values until the next exception.
REQ-029 exc_ack in RUN SHALL be ignored.
REQ-030 flush SHALL clear out_valid next cycle and discard any same-cycle input, including a faulting one; flush SHALL NOT clear a pending exception.
REQ-031 Priority per cycle: rst > flush > exc_ack > accept.
REQ-032 out_* data SHALL hold stable while out_valid & ~out_ready.

Reset
REQ-033 On rst: state RUN, out_valid 0, exc_valid 0, exc_cause 0, exc_epc 0, all out_* data 0; rst mid-exception or mid-stall SHALL drop all content.

Structure
REQ-034 Shared package alu_pkg SHALL hold ALU opcode constants (AND 0, OR 1, ADD 2, DIV 4, MUL 5, SUB 6, SLT 7, SLL 8, SRL 9, XOR 10, NOR 11, ADDR_W 12, ADDR_H 13), status bit indices, cause codes and the RUN/EXC state enum.
REQ-035 Detection logic SHALL be one combinational sub-module alu_exc_decode (inputs: control, status, control bits; outputs: hit, cause).

Verification
REQ-036 Add, result 0x10, status 0x00, out_ready 1 -> out_valid next cycle, out_result 0x10, no exception.
REQ-037 ADDR_W load, result 0x1002, status[3]=0, pc 0x400 -> exc_valid, cause 4'h4, epc 0x400, out_valid stays 0.
REQ-038 DIV with status[2]=1 and check_ovf with status[5]=1 same instruction -> cause 4'hF (priority).
REQ-039 out_ready 0 for 3 cycles with entry held -> in_ready 0, out_* unchanged; out_ready 1 with in_valid 1 -> back-to-back transfer.
REQ-040 Exception pending, three further in_valid pulses then exc_ack -> all three discarded, RUN next cycle, next instruction accepted.
REQ-041 flush and rst asserted while in EXC with entry held -> rst wins, all outputs zero next cycle.
